multicycle_controller: RTL

Moore-style control FSM for the multicycle MIPS datapath. It consumes the datapath's `opc`, `func` and `zero` status outputs. It drives every datapath control input to sequence fetch, decode, execute, memory and write-back, one instruction at a time. It sits beside the datapath at the processor top level and is the only source of its control signals.

---
 rtl/multicycle_controller_if.sv | 31 +++
 rtl/multicycle_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control/status bundle between the multicycle controller and the MIPS datapath
interface multicycle_controller_if;
    logic [5:0] opc;
    logic [5:0] func;
    logic       zero;
    logic       PCLoad;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegDst;
    logic       JalSig1;
    logic       MemToReg;
    logic       JalSig2;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOperation;
    logic [1:0] PCSrc;
    logic       halted;
    modport master (
        input  opc, func, zero,
        output PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg,
               JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, halted
    );
    modport slave (
        output opc, func, zero,
        input  PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1, MemToReg,
               JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation, PCSrc, halted
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the multicycle MIPS datapath; CTRL_ILLEGAL_HALT_EN adds a sticky HALT on illegal instructions
module multicycle_controller (
    input logic                      clk,
    input logic                      rst,
    multicycle_controller_if.master  bus
);
    typedef enum logic [3:0] {
        S_IF, S_ID, S_MEMADR, S_LW_MEM, S_LW_WB, S_SW_MEM, S_R_EX, S_R_WB,
        S_ADDI_EX, S_SLTI_EX, S_I_WB, S_BR, S_J, S_JAL, S_JR
`ifdef CTRL_ILLEGAL_HALT_EN
        , S_HALT
`endif
    } state_t;

    typedef struct packed {
        logic       pcload;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       jal1;
        logic       memtoreg;
        logic       jal2;
        logic       regwrite;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic [1:0] pcsrc;
    } ctl_t;

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;
    localparam logic [2:0] SLT = 3'b111;

`ifdef CTRL_ILLEGAL_HALT_EN
    localparam state_t S_ILL = S_HALT;
`else
    localparam state_t S_ILL = S_IF;
`endif

    state_t state_q, state_d;
    ctl_t   ctl_q, ctl_d;

    function automatic logic [2:0] r_op(logic [5:0] fn);
        return fn == 6'b100000 ? ADD :
               fn == 6'b100010 ? SUB :
               fn == 6'b100100 ? 3'b000 :
               fn == 6'b100101 ? 3'b001 : SLT;
    endfunction

    function automatic state_t next_state(state_t s, logic [5:0] op, logic [5:0] fn);
        case (s)
            S_IF:      return S_ID;
            S_ID: case (op)
                6'b000000: return fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010} ? S_R_EX :
                                  fn == 6'b001000 ? S_JR : S_ILL;
                6'b100011,
                6'b101011: return S_MEMADR;
                6'b000100,
                6'b000101: return S_BR;
                6'b000010: return S_J;
                6'b000011: return S_JAL;
                6'b001000: return S_ADDI_EX;
                6'b001010: return S_SLTI_EX;
                default:   return S_ILL;
            endcase
            S_MEMADR:  return op == 6'b100011 ? S_LW_MEM : S_SW_MEM;
            S_LW_MEM:  return S_LW_WB;
            S_R_EX:    return S_R_WB;
            S_ADDI_EX,
            S_SLTI_EX: return S_I_WB;
`ifdef CTRL_ILLEGAL_HALT_EN
            S_HALT:    return S_HALT;
`endif
            default:   return S_IF;
        endcase
    endfunction

    function automatic ctl_t decode(state_t s, logic [5:0] fn);
        ctl_t c;
        c = '0;
        case (s)
            S_IF:      begin c.pcload = 1'b1; c.memread = 1'b1; c.irwrite = 1'b1; c.srcb = 2'd1; c.aluop = ADD; end
            S_ID:      begin c.srcb = 2'd3; c.aluop = ADD; end
            S_MEMADR,
            S_ADDI_EX: begin c.srca = 1'b1; c.srcb = 2'd2; c.aluop = ADD; end
            S_SLTI_EX: begin c.srca = 1'b1; c.srcb = 2'd2; c.aluop = SLT; end
            S_LW_MEM:  begin c.iord = 1'b1; c.memread = 1'b1; end
            S_LW_WB:   c.regwrite = 1'b1;
            S_SW_MEM:  begin c.iord = 1'b1; c.memwrite = 1'b1; end
            S_R_EX:    begin c.srca = 1'b1; c.aluop = r_op(fn); end
            S_R_WB:    begin c.regdst = 1'b1; c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_I_WB:    begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            S_BR:      begin c.srca = 1'b1; c.aluop = SUB; c.pcsrc = 2'd2; end
            S_J:       begin c.pcsrc = 2'd1; c.pcload = 1'b1; end
            S_JAL:     begin c.pcsrc = 2'd1; c.pcload = 1'b1; c.jal1 = 1'b1; c.jal2 = 1'b1; c.regwrite = 1'b1; end
            S_JR:      begin c.pcsrc = 2'd3; c.pcload = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    // next state and the control word it will present, decoded one cycle ahead so outputs come straight from flops
    always_comb begin
        state_d = next_state(state_q, bus.opc, bus.func);
        ctl_d   = decode(state_d, bus.func);
    end

    // state and registered control word; reset lands on the fetch decode immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            ctl_q   <= decode(S_IF, 6'd0);
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
        end
    end

    // branch PC load follows the live zero flag; opc[0] separates bne from beq
    assign bus.PCLoad       = ctl_q.pcload | (state_q == S_BR && (bus.zero ^ bus.opc[0]));
    assign bus.IorD         = ctl_q.iord;
    assign bus.MemRead      = ctl_q.memread;
    assign bus.MemWrite     = ctl_q.memwrite;
    assign bus.IRWrite      = ctl_q.irwrite;
    assign bus.RegDst       = ctl_q.regdst;
    assign bus.JalSig1      = ctl_q.jal1;
    assign bus.MemToReg     = ctl_q.memtoreg;
    assign bus.JalSig2      = ctl_q.jal2;
    assign bus.RegWrite     = ctl_q.regwrite;
    assign bus.ALUSrcA      = ctl_q.srca;
    assign bus.ALUSrcB      = ctl_q.srcb;
    assign bus.ALUOperation = ctl_q.aluop;
    assign bus.PCSrc        = ctl_q.pcsrc;
`ifdef CTRL_ILLEGAL_HALT_EN
    assign bus.halted       = state_q == S_HALT;
`else
    assign bus.halted       = 1'b0;
`endif
endmodule
